// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column sync, frame priority
// decode and frame-level debounce with a committed key code and press pulse.
module keypad_scanner #(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_FRAMES);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [CW-1:0] dwell;
    logic [1:0]    row;
    logic          hit_found;
    logic [3:0]    hit_code;
    logic          prev_valid;
    logic [3:0]    prev_code;
    logic [MW-1:0] match;

    logic          col_hit;
    logic [1:0]    col_idx;
    logic          sample;
    logic          frame_end;
    logic          res_valid;
    logic [3:0]    res_code;
    logic          same;
    logic [MW-1:0] match_next;
    logic          commit;

    // Lowest-index low column in the row currently strobed.
    always_comb begin
        col_hit = 1'b0;
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync[c]) begin
                col_hit = 1'b1;
                col_idx = 2'(c);
            end
        end
    end

    always_comb begin
        sample    = (dwell == DWELL_LAST);
        frame_end = sample && (row == 2'd3);
        res_valid = hit_found | col_hit;
        res_code  = hit_found ? hit_code : {row, col_idx};
        same      = (res_valid == prev_valid) &&
                    (!res_valid || (res_code == prev_code));
        if (!same)
            match_next = MW'(1);
        else if (match == MATCH_MAX)
            match_next = match;
        else
            match_next = match + MW'(1);
        commit = (match_next == MATCH_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell <= '0;
            row   <= 2'd0;
            row_n <= 4'b1110;
        end else if (sample) begin
            dwell <= '0;
            row   <= row + 2'd1;
            row_n <= {row_n[2:0], row_n[3]};
        end else begin
            dwell <= dwell + CW'(1);
        end
    end

    // First hit in a frame wins, which gives row-then-column priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_found <= 1'b0;
            hit_code  <= 4'd0;
        end else if (frame_end) begin
            hit_found <= 1'b0;
            hit_code  <= 4'd0;
        end else if (sample && col_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_code  <= {row, col_idx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_code  <= 4'd0;
            match      <= '0;
        end else if (frame_end) begin
            match      <= match_next;
            prev_valid <= res_valid;
            prev_code  <= res_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (frame_end && commit) begin
                if (res_valid) begin
                    key_code  <= res_code;
                    key_valid <= 1'b1;
                    key_press <= !(key_valid && (key_code == res_code));
                end else begin
                    key_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and scenario-driven bench for keypad_scanner against a
// frame-level reference model of scan, priority and debounce rules.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DF = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;

    logic [15:0] keys = 16'h0;

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col_n(col_n),
        .row_n(row_n),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key shorts its column to its row strobe.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r])
                    col_n[c] = 1'b0;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int          k;
    logic [15:0] km1, km2;
    logic [15:0] frame_mask;
    int          res_q[$];
    logic [3:0]  e_row;
    int          e_code;
    bit          e_valid;
    bit          e_press;
    int          pulses;
    int          valid_cycles;

    function automatic int lowest_key(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return 16;
    endfunction

    task automatic model_reset();
        k = 0;
        km1 = 16'h0;
        km2 = 16'h0;
        frame_mask = 16'h0;
        res_q.delete();
        e_row = 4'b1110;
        e_code = 0;
        e_valid = 0;
        e_press = 0;
    endtask

    task automatic model_edge();
        int  best;
        int  row;
        bit  stable;
        e_press = 0;
        if (k % SD == SD - 1) begin
            row = (k / SD) % 4;
            frame_mask |= km2 & (16'hF << (row * 4));
        end
        if (k % FRAME == FRAME - 1) begin
            best = lowest_key(frame_mask);
            frame_mask = 16'h0;
            res_q.push_back(best);
            if (res_q.size() > DF) void'(res_q.pop_front());
            stable = (res_q.size() == DF);
            for (int i = 0; i < res_q.size(); i++)
                if (res_q[i] != best) stable = 0;
            if (stable) begin
                if (best == 16) begin
                    e_valid = 0;
                end else begin
                    e_press = !(e_valid && e_code == best);
                    e_valid = 1;
                    e_code = best;
                end
            end
        end
        e_row = ~(4'b0001 << (((k + 1) / SD) % 4));
        km2 = km1;
        km1 = keys;
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("row_n", int'(row_n), int'(e_row));
        check("key_code", int'(key_code), e_code);
        check("key_valid", int'(key_valid), int'(e_valid));
        check("key_press", int'(key_press), int'(e_press));
        if (key_press) pulses++;
        if (key_valid) valid_cycles++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_row_n", int'(row_n), 14);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_press", int'(key_press), 0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        run(6);
        do_reset();
        run(20);

        pulses = 0;
        keys = 16'h1 << 9;
        run(40);
        check("press9_code", int'(key_code), 9);
        check("press9_valid", int'(key_valid), 1);
        run(160);
        check("press9_pulses", pulses, 1);

        keys = 16'h0;
        run(50);
        pulses = 0;
        valid_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            keys = 16'h1 << 3;
            run(FRAME);
            keys = 16'h0;
            run(FRAME);
        end
        check("bounce_valid", valid_cycles, 0);
        check("bounce_pulses", pulses, 0);

        keys = 16'h1 << 5;
        run(50);
        check("chg_code5", int'(key_code), 5);
        pulses = 0;
        valid_cycles = 0;
        keys = 16'h1 << 14;
        run(50);
        check("chg_code14", int'(key_code), 14);
        check("chg_pulses", pulses, 1);
        check("chg_valid_held", valid_cycles, 50);
        keys = 16'h0;
        run(50);
        check("rel_valid", int'(key_valid), 0);
        check("rel_code", int'(key_code), 14);

        keys = (16'h1 << 6) | (16'h1 << 11);
        run(50);
        check("multi_code", int'(key_code), 6);
        keys = 16'h0;
        run(50);

        keys = 16'h1 << 15;
        run(FRAME);
        do_reset();
        pulses = 0;
        valid_cycles = 0;
        run(FRAME + 8);
        check("rstdb_valid", valid_cycles, 0);
        check("rstdb_pulses", pulses, 0);
        run(40);
        check("rstdb_code", int'(key_code), 15);
        check("rstdb_valid_end", int'(key_valid), 1);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: keys = 16'h0;
                1: keys = 16'h1 << $urandom_range(0, 15);
                2: keys = (16'h1 << $urandom_range(0, 15)) |
                          (16'h1 << $urandom_range(0, 15));
                default: keys = 16'($urandom);
            endcase
            run($urandom_range(8, 60));
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
